// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART TX arbiter slice
package uart_pkg;
  typedef enum logic {IDLE, GRANT} uart_txarb_state_e;
  localparam int UART_DLEN_DEFAULT = 8;
  function automatic int onehot_idx(input logic [31:0] v);
    onehot_idx = 0;
    for (int i = 0; i < 32; i++) if (v[i]) onehot_idx = i;
  endfunction
endpackage

// File: rtl/uart_rr_picker.sv
// uart_rr_picker: one-hot round-robin pick starting after rr_ptr
module uart_rr_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         pick,
  output logic                       any_req
);
  logic [$clog2(NUM_REQ)-1:0] idx;
  assign any_req = |req;
  // scan offsets from farthest to nearest so the nearest valid requester wins
  always_comb begin
    pick = '0;
    idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = $clog2(NUM_REQ)'((int'(rr_ptr) + i) % NUM_REQ);
      if (req[idx]) pick = NUM_REQ'(1) << idx;
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet-locked arbiter into the UART TX buffer; optional grant timeout via UART_TXARB_TIMEOUT_EN
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int UART_DLEN      = UART_DLEN_DEFAULT,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           i_req_tvalid,
  output logic [NUM_REQ-1:0]           o_req_tready,
  input  logic [NUM_REQ*UART_DLEN-1:0] i_req_tdata,
  input  logic [NUM_REQ-1:0]           i_req_tlast,
  output logic                         o_txb_tvalid,
  input  logic                         i_txb_tready,
  output logic [UART_DLEN-1:0]         o_txb_tdata,
  input  logic                         i_txb_overflow,
  output logic [NUM_REQ-1:0]           o_grant,
  output logic                         o_busy,
  output logic                         o_timeout
);
  localparam int PW = $clog2(NUM_REQ);
  uart_txarb_state_e state;
  logic [PW-1:0] rr_ptr;
  logic [NUM_REQ-1:0] pick, hs_vec;
  logic any_req, hs, last, revoke;
  logic [UART_DLEN-1:0] sel_data;

  uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req(i_req_tvalid), .rr_ptr(rr_ptr), .pick(pick), .any_req(any_req)
  );

  assign o_req_tready = (state == GRANT && (~o_txb_tvalid | i_txb_tready)) ? o_grant : '0;
  assign hs_vec = i_req_tvalid & o_req_tready;
  assign hs = |hs_vec;
  assign last = |(hs_vec & i_req_tlast);
  assign o_busy = (state == GRANT) | o_txb_tvalid;
  assign o_timeout = revoke;

  // data of the currently granted requester
  always_comb begin
    sel_data = '0;
    for (int r = 0; r < NUM_REQ; r++) if (o_grant[r]) sel_data = i_req_tdata[r*UART_DLEN +: UART_DLEN];
  end

`ifdef UART_TXARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] stall_cnt;
  logic stall;
  assign stall = ~|(i_req_tvalid & o_grant);
  assign revoke = state == GRANT && stall && stall_cnt == CW'(TIMEOUT_CYCLES - 1);
  // counts cycles the granted requester leaves its valid low
  always_ff @(posedge clk) begin
    if (rst || state != GRANT || hs || revoke) stall_cnt <= '0;
    else if (stall) stall_cnt <= stall_cnt + 1'b1;
  end
`else
  assign revoke = 1'b0;
`endif

  // arbitration FSM: grant in IDLE, release on tlast handshake or revoke
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      o_grant <= '0;
      rr_ptr <= PW'(NUM_REQ - 1);
    end else if (state == IDLE) begin
      if (any_req && !i_txb_overflow) begin
        state <= GRANT;
        o_grant <= pick;
      end
    end else if (last || revoke) begin
      state <= IDLE;
      o_grant <= '0;
      rr_ptr <= PW'(onehot_idx(32'(o_grant)));
    end
  end

  // single registered output stage toward the TX buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      o_txb_tvalid <= 1'b0;
      o_txb_tdata <= '0;
    end else if (hs) begin
      o_txb_tvalid <= 1'b1;
      o_txb_tdata <= sel_data;
    end else if (i_txb_tready) begin
      o_txb_tvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized scoreboard bench with round-robin reference model
module tb_uart_tx_arbiter;
  localparam int N = 4, W = 8, TO = 16;
  typedef struct packed {logic last; logic [W-1:0] data;} beat_t;
  logic clk = 0, rst = 1;
  logic [N-1:0] i_req_tvalid, o_req_tready, i_req_tlast, o_grant;
  logic [N*W-1:0] i_req_tdata;
  logic o_txb_tvalid, i_txb_tready, i_txb_overflow, o_busy, o_timeout;
  logic [W-1:0] o_txb_tdata;
  beat_t src_q[N][$];
  logic [W-1:0] exp_q[$];
  logic [N-1:0] gseq[$];
  int cmp = 0, err = 0;
  int vprob = 100, tr_mode = 1, ovf_mode = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .UART_DLEN(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .i_req_tvalid(i_req_tvalid), .o_req_tready(o_req_tready),
    .i_req_tdata(i_req_tdata), .i_req_tlast(i_req_tlast), .o_txb_tvalid(o_txb_tvalid),
    .i_txb_tready(i_txb_tready), .o_txb_tdata(o_txb_tdata), .i_txb_overflow(i_txb_overflow),
    .o_grant(o_grant), .o_busy(o_busy), .o_timeout(o_timeout)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int lw);
    for (int i = 1; i <= N; i++) if (v[(lw + i) % N]) return N'(1) << ((lw + i) % N);
    return '0;
  endfunction

  task automatic put(input int r, input logic [W-1:0] d, input logic l);
    beat_t b;
    b.last = l;
    b.data = d;
    src_q[r].push_back(b);
  endtask

  // requester and TX-buffer driver
  initial begin
    logic [N-1:0] hs;
    logic rs;
    i_req_tvalid = '0; i_req_tdata = '0; i_req_tlast = '0; i_txb_tready = 1; i_txb_overflow = 0;
    forever begin
      @(negedge clk);
      hs = i_req_tvalid & o_req_tready;
      rs = rst;
      @(posedge clk); #1;
      for (int r = 0; r < N; r++) begin
        if (rs) begin
          src_q[r].delete();
          i_req_tvalid[r] = 0;
        end else begin
          if (hs[r]) void'(src_q[r].pop_front());
          if (!(i_req_tvalid[r] && !hs[r]))
            i_req_tvalid[r] = src_q[r].size() > 0 && int'($urandom_range(0, 99)) < vprob;
          if (i_req_tvalid[r]) begin
            i_req_tdata[r*W +: W] = src_q[r][0].data;
            i_req_tlast[r] = src_q[r][0].last;
          end
        end
      end
      i_txb_tready = tr_mode == 2 ? ($urandom_range(0, 3) != 0) : (tr_mode == 1);
      i_txb_overflow = ovf_mode == 2 ? ($urandom_range(0, 7) == 0) : (ovf_mode == 1);
    end
  end

  // monitor: scoreboard for data, reference model for grants
  logic [N-1:0] p_grant = '0, p_valid = '0, hs_m;
  logic p_ovf = 0, p_rst = 1, p_end = 0, p_ov = 0, p_or = 0;
  logic [W-1:0] p_data = '0;
  int last_win = N - 1;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      last_win = N - 1;
      p_rst = 1;
    end else begin
      if (p_rst) chk("reset_state", {o_grant, o_txb_tvalid, o_txb_tdata, o_busy, o_timeout}, 0);
      else begin
        chk("grant", o_grant, p_grant == 0 ? ((p_valid != 0 && !p_ovf) ? rr_pick(p_valid, last_win) : '0)
                                          : (p_end ? '0 : p_grant));
        if (p_grant == 0 && o_grant != 0) gseq.push_back(o_grant);
        if (p_ov && !p_or) chk("hold", {o_txb_tvalid, o_txb_tdata}, {1'b1, p_data});
      end
      chk("tready", o_req_tready, o_grant & {N{!o_txb_tvalid || i_txb_tready}});
      chk("busy", o_busy, o_grant != 0 || o_txb_tvalid);
`ifndef UART_TXARB_TIMEOUT_EN
      chk("timeout_off", o_timeout, 0);
`endif
      if (o_txb_tvalid && i_txb_tready) begin
        if (exp_q.size() == 0) chk("spurious_beat", {o_txb_tvalid, o_txb_tdata}, 0);
        else chk("data", o_txb_tdata, exp_q.pop_front());
      end
      hs_m = i_req_tvalid & o_req_tready;
      for (int r = 0; r < N; r++) if (hs_m[r]) exp_q.push_back(i_req_tdata[r*W +: W]);
      p_end = |(hs_m & i_req_tlast) | o_timeout;
      if (p_end) for (int r = 0; r < N; r++) if (o_grant[r]) last_win = r;
      p_rst = 0;
    end
    p_grant = o_grant; p_valid = i_req_tvalid; p_ovf = i_txb_overflow;
    p_ov = o_txb_tvalid; p_or = i_txb_tready; p_data = o_txb_tdata;
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic drain(input string nm);
    int k = 0, pend;
    do begin
      pend = exp_q.size() + int'(o_txb_tvalid) + int'(o_grant != 0);
      for (int r = 0; r < N; r++) pend += src_q[r].size();
      if (pend != 0) begin @(negedge clk); k++; end
    end while (pend != 0 && k < 5000);
    chk({nm, "_drain"}, k < 5000, 1);
  endtask

  task automatic wait_grant(input logic [N-1:0] g, input string nm);
    int k = 0;
    while (o_grant != g && k < 50) begin @(negedge clk); k++; end
    chk({nm, "_grant_seen"}, o_grant, g);
  endtask

  initial begin
    int k, t0, stalls;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    // single 3-beat packet: latency and streaming
    @(negedge clk);
    put(0, 8'h41, 0); put(0, 8'h42, 0); put(0, 8'h43, 1);
    k = 0;
    while (!i_req_tvalid[0] && k < 10) begin @(negedge clk); k++; end
    t0 = k;
    while (!o_txb_tvalid && k < 20) begin @(negedge clk); k++; end
    chk("t1_latency", 32'(k - t0), 2);
    chk("t1_b0", {o_txb_tvalid, o_txb_tdata}, {1'b1, 8'h41});
    @(negedge clk); chk("t1_b1", {o_txb_tvalid, o_txb_tdata}, {1'b1, 8'h42});
    @(negedge clk); chk("t1_b2", {o_txb_tvalid, o_txb_tdata}, {1'b1, 8'h43});
    drain("t1");
    // all requesters with single-beat packets: round-robin order
    do_reset();
    @(negedge clk);
    gseq.delete();
    for (int rep = 0; rep < 2; rep++) for (int r = 0; r < N; r++) put(r, 8'(r * 16 + rep), 1);
    drain("t2");
    chk("t2_count", gseq.size(), 8);
    for (int i = 0; i < 8; i++) if (i < gseq.size()) chk("t2_order", gseq[i], N'(1) << (i % N));
    // packet lock: req2 waits for req1's tlast
    gseq.delete();
    put(1, 8'hA0, 0); put(1, 8'hA1, 0); put(1, 8'hA2, 0); put(1, 8'hA3, 1);
    wait_grant(4'b0010, "t3");
    put(2, 8'hB0, 1);
    drain("t3");
    chk("t3_count", gseq.size(), 2);
    if (gseq.size() == 2) begin
      chk("t3_first", gseq[0], 4'b0010);
      chk("t3_second", gseq[1], 4'b0100);
    end
    // TX buffer back-pressure
    tr_mode = 0;
    put(0, 8'h55, 0); put(0, 8'h56, 1);
    k = 0;
    while (!o_txb_tvalid && k < 20) begin @(negedge clk); k++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold", {o_txb_tvalid, o_txb_tdata}, {1'b1, 8'h55});
      chk("t4_tready", o_req_tready, 0);
    end
    tr_mode = 1;
    drain("t4");
    // overflow blocks new grants
    ovf_mode = 1;
    @(negedge clk); @(negedge clk);
    put(3, 8'h33, 1);
    for (int i = 0; i < 4; i++) begin @(negedge clk); chk("t5_blocked", o_grant, 0); end
    ovf_mode = 0;
    @(negedge clk); @(negedge clk);
    chk("t5_grant", o_grant, 4'b1000);
    drain("t5");
    // reset in the middle of a packet
    for (int i = 0; i < 6; i++) put(2, 8'hC0 + 8'(i), i == 5);
    k = 0;
    while (!o_txb_tvalid && k < 20) begin @(negedge clk); k++; end
    tr_mode = 0;
    @(negedge clk);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("t7_after_rst", {o_txb_tvalid, o_grant}, 0);
    tr_mode = 1;
    drain("t7");
`ifdef UART_TXARB_TIMEOUT_EN
    // stalled grant is revoked after the timeout
    gseq.delete();
    put(0, 8'h10, 0);
    wait_grant(4'b0001, "t6");
    put(1, 8'h20, 1);
    k = 0; stalls = 0;
    do begin
      @(negedge clk); k++;
      if (o_grant == 4'b0001 && !i_req_tvalid[0]) stalls++;
    end while (!o_timeout && k < 60);
    chk("t6_stalls", stalls, 16);
    drain("t6");
    chk("t6_count", gseq.size(), 2);
    if (gseq.size() == 2) chk("t6_next", gseq[1], 4'b0010);
`else
    stalls = 0;
`endif
    // randomized traffic
    vprob = 60; tr_mode = 2; ovf_mode = 2;
    for (int p = 0; p < 80; p++) begin
      int r, len;
      r = int'($urandom_range(0, N - 1));
      len = int'($urandom_range(1, 5));
      for (int b = 0; b < len; b++) put(r, 8'($urandom), b == len - 1);
    end
    drain("rand");
    vprob = 100; tr_mode = 1; ovf_mode = 0;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", cmp, err);
    $fatal(1);
  end
endmodule
